// File: rtl/cmd_frame_assembler.sv
// cmd_frame_assembler
//
// Turns the stream of synchronized UART RX bytes in the REF_CLK domain into
// fully decoded command frames for the system controller. The frames are
// register-file write, register-file read, ALU operation with operands, and
// ALU operation without operands. One command is offered per valid/ready
// handshake. The block also reports malformed frames, inter-byte timeouts
// and overruns through a single-cycle error strobe.
//
// Ports:
//   CLK        - REF clock domain clock
//   RST        - synchronous active-high reset
//   RX_P_DATA  - synchronized received byte
//   RX_D_VLD   - single-cycle strobe, RX_P_DATA valid this cycle
//   CMD_READY  - controller accepts the held command
//   CMD_VALID  - a complete command is held on the CMD_* outputs
//   CMD_TYPE   - 0 = RF_WR, 1 = RF_RD, 2 = ALU_OP, 3 = ALU_NOP
//   CMD_ADDR   - register-file address
//   CMD_DATA   - register-file write data
//   CMD_OPA    - ALU operand A
//   CMD_OPB    - ALU operand B
//   CMD_FUN    - ALU function
//   ERR_PULSE  - single-cycle error strobe
//   ERR_CODE   - 0 = overrun, 1 = bad opcode, 2 = bad field, 3 = timeout
//   BUSY       - high whenever a frame is being collected or held
module cmd_frame_assembler #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  CMD_READY,
    output logic                  CMD_VALID,
    output logic [1:0]            CMD_TYPE,
    output logic [ADDR_WIDTH-1:0] CMD_ADDR,
    output logic [DATA_WIDTH-1:0] CMD_DATA,
    output logic [DATA_WIDTH-1:0] CMD_OPA,
    output logic [DATA_WIDTH-1:0] CMD_OPB,
    output logic [3:0]            CMD_FUN,
    output logic                  ERR_PULSE,
    output logic [1:0]            ERR_CODE,
    output logic                  BUSY
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

    localparam logic [DATA_WIDTH-1:0] OP_RF_WR   = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_RF_RD   = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OP_ALU_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OP_ALU_NOP = DATA_WIDTH'(8'hDD);

    localparam logic [1:0] ERR_OVERRUN    = 2'd0;
    localparam logic [1:0] ERR_BAD_OPCODE = 2'd1;
    localparam logic [1:0] ERR_BAD_FIELD  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT    = 2'd3;

    typedef enum logic [1:0] {
        CMD_RF_WR   = 2'd0,
        CMD_RF_RD   = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_t;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        GET_OPA,
        GET_OPB,
        GET_FUN,
        HOLD
    } state_t;

    state_t                  state;
    cmd_type_t               frame_type;
    logic [ADDR_WIDTH-1:0]   addr_stage;
    logic [DATA_WIDTH-1:0]   opa_stage;
    logic [DATA_WIDTH-1:0]   opb_stage;
    logic [CNT_WIDTH-1:0]    to_count;

    logic                    addr_bad;
    logic                    fun_bad;

    // Field legality of the incoming byte, used only in the states that
    // expect an address or a function byte.
    assign addr_bad = |(RX_P_DATA >> ADDR_WIDTH);
    assign fun_bad  = |RX_P_DATA[DATA_WIDTH-1:4];

    // Frame sequencer. Intermediate fields are staged internally so the
    // CMD_* outputs only change when a frame completes; a dropped frame
    // therefore leaves the previously delivered command untouched.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            frame_type <= CMD_RF_WR;
            addr_stage <= '0;
            opa_stage  <= '0;
            opb_stage  <= '0;
            to_count   <= '0;
            CMD_VALID  <= 1'b0;
            CMD_TYPE   <= '0;
            CMD_ADDR   <= '0;
            CMD_DATA   <= '0;
            CMD_OPA    <= '0;
            CMD_OPB    <= '0;
            CMD_FUN    <= '0;
            ERR_PULSE  <= 1'b0;
            ERR_CODE   <= '0;
            BUSY       <= 1'b0;
        end else begin
            ERR_PULSE <= 1'b0;

            if (state == IDLE) begin
                to_count <= '0;
                if (RX_D_VLD) begin
                    BUSY <= 1'b1;
                    case (RX_P_DATA)
                        OP_RF_WR: begin
                            frame_type <= CMD_RF_WR;
                            state      <= GET_ADDR;
                        end
                        OP_RF_RD: begin
                            frame_type <= CMD_RF_RD;
                            state      <= GET_ADDR;
                        end
                        OP_ALU_OP: begin
                            frame_type <= CMD_ALU_OP;
                            state      <= GET_OPA;
                        end
                        OP_ALU_NOP: begin
                            frame_type <= CMD_ALU_NOP;
                            state      <= GET_FUN;
                        end
                        default: begin
                            BUSY      <= 1'b0;
                            ERR_PULSE <= 1'b1;
                            ERR_CODE  <= ERR_BAD_OPCODE;
                        end
                    endcase
                end
            end else if (state == HOLD) begin
                // A byte here is lost even on the handshake cycle; the held
                // command itself is never modified by it.
                if (RX_D_VLD) begin
                    ERR_PULSE <= 1'b1;
                    ERR_CODE  <= ERR_OVERRUN;
                end
                if (CMD_READY) begin
                    CMD_VALID <= 1'b0;
                    state     <= IDLE;
                    BUSY      <= 1'b0;
                end
            end else begin
                // Collecting a frame: a byte always wins over a timeout
                // that would expire in the same cycle.
                if (RX_D_VLD) begin
                    to_count <= '0;
                    case (state)
                        GET_ADDR: begin
                            if (addr_bad) begin
                                ERR_PULSE <= 1'b1;
                                ERR_CODE  <= ERR_BAD_FIELD;
                                state     <= IDLE;
                                BUSY      <= 1'b0;
                            end else if (frame_type == CMD_RF_RD) begin
                                CMD_TYPE  <= CMD_RF_RD;
                                CMD_ADDR  <= RX_P_DATA[ADDR_WIDTH-1:0];
                                CMD_VALID <= 1'b1;
                                state     <= HOLD;
                            end else begin
                                addr_stage <= RX_P_DATA[ADDR_WIDTH-1:0];
                                state      <= GET_DATA;
                            end
                        end
                        GET_DATA: begin
                            CMD_TYPE  <= CMD_RF_WR;
                            CMD_ADDR  <= addr_stage;
                            CMD_DATA  <= RX_P_DATA;
                            CMD_VALID <= 1'b1;
                            state     <= HOLD;
                        end
                        GET_OPA: begin
                            opa_stage <= RX_P_DATA;
                            state     <= GET_OPB;
                        end
                        GET_OPB: begin
                            opb_stage <= RX_P_DATA;
                            state     <= GET_FUN;
                        end
                        GET_FUN: begin
                            if (fun_bad) begin
                                ERR_PULSE <= 1'b1;
                                ERR_CODE  <= ERR_BAD_FIELD;
                                state     <= IDLE;
                                BUSY      <= 1'b0;
                            end else begin
                                CMD_FUN   <= RX_P_DATA[3:0];
                                CMD_VALID <= 1'b1;
                                state     <= HOLD;
                                if (frame_type == CMD_ALU_OP) begin
                                    CMD_TYPE <= CMD_ALU_OP;
                                    CMD_OPA  <= opa_stage;
                                    CMD_OPB  <= opb_stage;
                                end else begin
                                    CMD_TYPE <= CMD_ALU_NOP;
                                end
                            end
                        end
                        default: begin
                        end
                    endcase
                end else if (to_count == TIMEOUT_LIMIT) begin
                    ERR_PULSE <= 1'b1;
                    ERR_CODE  <= ERR_TIMEOUT;
                    state     <= IDLE;
                    BUSY      <= 1'b0;
                    to_count  <= '0;
                end else begin
                    to_count <= to_count + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cmd_frame_assembler.sv
// tb_cmd_frame_assembler
//
// Self-checking bench for cmd_frame_assembler with an 8-cycle timeout.
// A table of directed vectors, several hand-written multi-cycle sequences
// and a randomized phase are all compared cycle by cycle against a
// frame-level reference model that tracks the bytes collected so far.
module tb_cmd_frame_assembler;

    localparam int TO = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] RX_P_DATA = 8'h00;
    logic       RX_D_VLD = 1'b0;
    logic       CMD_READY = 1'b0;
    logic       CMD_VALID;
    logic [1:0] CMD_TYPE;
    logic [3:0] CMD_ADDR;
    logic [7:0] CMD_DATA;
    logic [7:0] CMD_OPA;
    logic [7:0] CMD_OPB;
    logic [3:0] CMD_FUN;
    logic       ERR_PULSE;
    logic [1:0] ERR_CODE;
    logic       BUSY;

    typedef struct packed {
        logic       valid;
        logic [1:0] ctype;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] opa;
        logic [7:0] opb;
        logic [3:0] fun;
        logic       pulse;
        logic [1:0] code;
        logic       busy;
    } out_t;

    typedef struct {
        logic       vld;
        logic [7:0] data;
        logic       rdy;
        out_t       exp;
    } vec_t;

    out_t dut_out;
    assign dut_out = {CMD_VALID, CMD_TYPE, CMD_ADDR, CMD_DATA, CMD_OPA,
                      CMD_OPB, CMD_FUN, ERR_PULSE, ERR_CODE, BUSY};

    int tests = 0;
    int failures = 0;

    // Reference model state: bytes of the frame in progress, idle gap since
    // the last accepted byte, whether a finished command is being offered,
    // and the output values the block should present.
    logic [7:0] partial[$];
    int         gap = 0;
    bit         holding = 0;
    out_t       m = '0;

    cmd_frame_assembler #(
        .DATA_WIDTH     (8),
        .ADDR_WIDTH     (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_P_DATA (RX_P_DATA),
        .RX_D_VLD  (RX_D_VLD),
        .CMD_READY (CMD_READY),
        .CMD_VALID (CMD_VALID),
        .CMD_TYPE  (CMD_TYPE),
        .CMD_ADDR  (CMD_ADDR),
        .CMD_DATA  (CMD_DATA),
        .CMD_OPA   (CMD_OPA),
        .CMD_OPB   (CMD_OPB),
        .CMD_FUN   (CMD_FUN),
        .ERR_PULSE (ERR_PULSE),
        .ERR_CODE  (ERR_CODE),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    // Total frame length in bytes for an opcode, 0 if the opcode is illegal.
    function automatic int frameLen(input logic [7:0] op);
        case (op)
            8'hAA:   return 3;
            8'hBB:   return 2;
            8'hCC:   return 4;
            8'hDD:   return 2;
            default: return 0;
        endcase
    endfunction

    // True when byte position k of the frame is an address or function field,
    // both of which must fit in 4 bits.
    function automatic bit isNarrowField(input logic [7:0] op, input int k);
        case (op)
            8'hAA:   return k == 1;
            8'hBB:   return k == 1;
            8'hCC:   return k == 3;
            8'hDD:   return k == 1;
            default: return 0;
        endcase
    endfunction

    function automatic out_t mkOut(input logic v, input logic [1:0] t,
                                   input logic [3:0] a, input logic [7:0] d,
                                   input logic [7:0] oa, input logic [7:0] ob,
                                   input logic [3:0] f, input logic p,
                                   input logic [1:0] c, input logic b);
        return {v, t, a, d, oa, ob, f, p, c, b};
    endfunction

    task automatic raiseErr(input logic [1:0] code);
        m.pulse = 1'b1;
        m.code  = code;
    endtask

    // Deliver the finished frame in partial[] as the new held command.
    task automatic commitFrame();
        logic [7:0] op;
        op = partial[0];
        case (op)
            8'hAA: begin
                m.ctype = 2'd0;
                m.addr  = partial[1][3:0];
                m.data  = partial[2];
            end
            8'hBB: begin
                m.ctype = 2'd1;
                m.addr  = partial[1][3:0];
            end
            8'hCC: begin
                m.ctype = 2'd2;
                m.opa   = partial[1];
                m.opb   = partial[2];
                m.fun   = partial[3][3:0];
            end
            default: begin
                m.ctype = 2'd3;
                m.fun   = partial[1][3:0];
            end
        endcase
        m.valid = 1'b1;
        holding = 1;
        partial.delete();
    endtask

    // Advance the model by one clock edge given the inputs sampled there.
    task automatic modelStep(input bit rst, input bit vld,
                             input logic [7:0] data, input bit rdy);
        if (rst) begin
            m = '0;
            partial.delete();
            gap = 0;
            holding = 0;
            return;
        end
        m.pulse = 1'b0;
        if (holding) begin
            if (vld) raiseErr(2'd0);
            if (rdy) begin
                holding = 0;
                m.valid = 1'b0;
            end
        end else if (partial.size() == 0) begin
            if (vld) begin
                if (frameLen(data) > 0) begin
                    partial.push_back(data);
                    gap = 0;
                end else begin
                    raiseErr(2'd1);
                end
            end
        end else if (vld) begin
            gap = 0;
            if (isNarrowField(partial[0], partial.size()) && data > 8'd15) begin
                raiseErr(2'd2);
                partial.delete();
            end else begin
                partial.push_back(data);
                if (partial.size() == frameLen(partial[0])) commitFrame();
            end
        end else if (gap == TO) begin
            raiseErr(2'd3);
            partial.delete();
            gap = 0;
        end else begin
            gap++;
        end
        m.busy = holding || (partial.size() != 0);
    endtask

    task automatic checkOutput(input string name, input out_t exp);
        tests++;
        if (dut_out !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, dut_out, exp);
        end
    endtask

    task automatic applyStimulus(input bit vld, input logic [7:0] data,
                                 input bit rdy, input string name);
        RX_D_VLD  = vld;
        RX_P_DATA = data;
        CMD_READY = rdy;
        @(posedge CLK);
        #1;
        modelStep(0, vld, data, rdy);
        checkOutput(name, m);
    endtask

    task automatic doReset(input string name);
        RST       = 1'b1;
        RX_D_VLD  = 1'b0;
        CMD_READY = 1'b0;
        @(posedge CLK);
        #1;
        modelStep(1, 0, 8'h00, 0);
        checkOutput(name, '0);
        RST = 1'b0;
    endtask

    vec_t vecs[18];

    initial begin
        int         pulse_at;
        logic [7:0] ops[4];
        ops = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

        // Fields: valid, type, addr, data, opa, opb, fun, pulse, code, busy
        vecs[0]  = '{1'b1, 8'hAA, 1'b1, mkOut(1'b0, 2'd0, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 2'd0, 1'b1)};
        vecs[1]  = '{1'b1, 8'h05, 1'b1, mkOut(1'b0, 2'd0, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 2'd0, 1'b1)};
        vecs[2]  = '{1'b1, 8'h3C, 1'b1, mkOut(1'b1, 2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 1'b0, 2'd0, 1'b1)};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, mkOut(1'b0, 2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 1'b0, 2'd0, 1'b0)};
        vecs[4]  = '{1'b1, 8'h55, 1'b1, mkOut(1'b0, 2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 1'b1, 2'd1, 1'b0)};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, mkOut(1'b0, 2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 1'b0, 2'd1, 1'b0)};
        vecs[6]  = '{1'b1, 8'hBB, 1'b1, mkOut(1'b0, 2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 1'b0, 2'd1, 1'b1)};
        vecs[7]  = '{1'b1, 8'h15, 1'b1, mkOut(1'b0, 2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 1'b1, 2'd2, 1'b0)};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, mkOut(1'b0, 2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 1'b0, 2'd2, 1'b0)};
        vecs[9]  = '{1'b1, 8'hDD, 1'b1, mkOut(1'b0, 2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 1'b0, 2'd2, 1'b1)};
        vecs[10] = '{1'b1, 8'h0A, 1'b1, mkOut(1'b1, 2'd3, 4'h5, 8'h3C, 8'h00, 8'h00, 4'hA, 1'b0, 2'd2, 1'b1)};
        vecs[11] = '{1'b0, 8'h00, 1'b1, mkOut(1'b0, 2'd3, 4'h5, 8'h3C, 8'h00, 8'h00, 4'hA, 1'b0, 2'd2, 1'b0)};
        vecs[12] = '{1'b1, 8'hBB, 1'b1, mkOut(1'b0, 2'd3, 4'h5, 8'h3C, 8'h00, 8'h00, 4'hA, 1'b0, 2'd2, 1'b1)};
        vecs[13] = '{1'b1, 8'h09, 1'b1, mkOut(1'b1, 2'd1, 4'h9, 8'h3C, 8'h00, 8'h00, 4'hA, 1'b0, 2'd2, 1'b1)};
        vecs[14] = '{1'b1, 8'hDD, 1'b1, mkOut(1'b0, 2'd1, 4'h9, 8'h3C, 8'h00, 8'h00, 4'hA, 1'b1, 2'd0, 1'b0)};
        vecs[15] = '{1'b0, 8'h00, 1'b1, mkOut(1'b0, 2'd1, 4'h9, 8'h3C, 8'h00, 8'h00, 4'hA, 1'b0, 2'd0, 1'b0)};
        vecs[16] = '{1'b1, 8'hDD, 1'b1, mkOut(1'b0, 2'd1, 4'h9, 8'h3C, 8'h00, 8'h00, 4'hA, 1'b0, 2'd0, 1'b1)};
        vecs[17] = '{1'b1, 8'h1F, 1'b1, mkOut(1'b0, 2'd1, 4'h9, 8'h3C, 8'h00, 8'h00, 4'hA, 1'b1, 2'd2, 1'b0)};

        doReset("reset_initial");

        // Directed vectors: RF_WR, bad opcode, bad address, ALU_NOP, RF_RD,
        // overrun on the handshake cycle, bad function nibble.
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].vld, vecs[i].data, vecs[i].rdy, $sformatf("vec%0d_model", i));
            checkOutput($sformatf("vec%0d_table", i), vecs[i].exp);
        end

        // ALU_OP held under backpressure, then an overrun, then release.
        applyStimulus(1, 8'hCC, 0, "alu_op");
        applyStimulus(1, 8'h12, 0, "alu_opa");
        applyStimulus(1, 8'h34, 0, "alu_opb");
        applyStimulus(1, 8'h01, 0, "alu_fun");
        checkOutput("alu_held", mkOut(1'b1, 2'd2, 4'h9, 8'h3C, 8'h12, 8'h34, 4'h1, 1'b0, 2'd2, 1'b1));
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 8'h00, 0, "alu_wait_model");
            checkOutput($sformatf("alu_stable%0d", i),
                        mkOut(1'b1, 2'd2, 4'h9, 8'h3C, 8'h12, 8'h34, 4'h1, 1'b0, 2'd2, 1'b1));
        end
        applyStimulus(1, 8'h77, 0, "overrun");
        checkOutput("overrun_hold", mkOut(1'b1, 2'd2, 4'h9, 8'h3C, 8'h12, 8'h34, 4'h1, 1'b1, 2'd0, 1'b1));
        applyStimulus(0, 8'h00, 0, "overrun_after");
        applyStimulus(0, 8'h00, 1, "alu_release");
        checkOutput("alu_released", mkOut(1'b0, 2'd2, 4'h9, 8'h3C, 8'h12, 8'h34, 4'h1, 1'b0, 2'd0, 1'b0));

        // Timeout: silence after the second byte of an RF_WR frame.
        applyStimulus(1, 8'hAA, 1, "to_op");
        applyStimulus(1, 8'h03, 1, "to_addr");
        pulse_at = 0;
        for (int k = 1; k <= TO + 4; k++) begin
            applyStimulus(0, 8'h00, 1, $sformatf("to_idle%0d", k));
            if (ERR_PULSE === 1'b1 && pulse_at == 0) pulse_at = k;
        end
        tests++;
        if (pulse_at != TO + 1 || ERR_CODE !== 2'd3) begin
            failures++;
            $display("[TB] FAIL timeout_latency: pulse after %0d cycles (code %0d), expected %0d cycles (code 3)",
                     pulse_at, ERR_CODE, TO + 1);
        end

        // A byte on the very cycle the timeout would fire completes the frame.
        applyStimulus(1, 8'hAA, 0, "tob_op");
        applyStimulus(1, 8'h03, 0, "tob_addr");
        for (int k = 1; k <= TO; k++) applyStimulus(0, 8'h00, 0, "tob_idle");
        applyStimulus(1, 8'h44, 0, "tob_data");
        checkOutput("timeout_byte_wins", mkOut(1'b1, 2'd0, 4'h3, 8'h44, 8'h12, 8'h34, 4'h1, 1'b0, 2'd3, 1'b1));
        applyStimulus(0, 8'h00, 1, "tob_release");

        // Reset mid-frame, then an ALU_NOP frame from a clean state.
        applyStimulus(1, 8'hAA, 0, "rst_op");
        doReset("reset_midframe");
        applyStimulus(1, 8'hDD, 0, "nop_op");
        applyStimulus(1, 8'h0A, 0, "nop_fun");
        checkOutput("nop_after_reset", mkOut(1'b1, 2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'hA, 1'b0, 2'd0, 1'b1));
        applyStimulus(0, 8'h00, 1, "nop_release");

        // Randomized traffic: a dense phase, a low-ready phase and a sparse
        // phase that lets timeouts expire, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            int         phase;
            bit         vld;
            bit         rdy;
            logic [7:0] data;
            int         sel;
            phase = i / 200;
            if ($urandom_range(0, 299) == 0) begin
                doReset("rand_reset");
            end else begin
                vld = (phase == 2) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 6);
                rdy = (phase == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
                sel = int'($urandom_range(0, 3));
                if (sel < 2)       data = ops[$urandom_range(0, 3)];
                else if (sel == 2) data = 8'($urandom_range(0, 15));
                else               data = 8'($urandom_range(0, 255));
                applyStimulus(vld, data, rdy, $sformatf("rand%0d", i));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
